// File: rtl/alu_pkg.sv
// ALU control encodings and legality check, shared by the ALU and the
// arbiter that feeds it.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
        logic legal;
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default:                                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; unknown control codes produce a zero result.
module ALU
    import alu_pkg::*;
(
    input  logic [3:0]  ctrl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'd0, (a < b)};  // unsigned compare
            ALU_NOR: result = ~(a | b);
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the issue path (0) and the
// branch/compare unit (1), with a one-entry registered response buffer.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_id,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    logic             last_reg;
    logic             rsp_valid_reg;
    logic [31:0]      rsp_result_reg;
    logic             rsp_zero_reg;
    logic             rsp_neg_reg;
    logic             rsp_id_reg;
    logic             rsp_illegal_reg;
    logic [CNT_W-1:0] cnt_reg [2];

    logic        can_accept;
    logic        winner;
    logic        accept;
    logic [1:0]  grant;
    logic [31:0] mux_a;
    logic [31:0] mux_b;
    logic [3:0]  mux_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;

    assign can_accept = !rst && (!rsp_valid_reg || rsp_ready);

    // Winner depends only on the valids and the last grant, never on ready.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid)
            winner = ~last_reg;
        else if (req1_valid)
            winner = 1'b1;
    end

    assign req0_ready = can_accept && req0_valid && (winner == 1'b0);
    assign req1_ready = can_accept && req1_valid && (winner == 1'b1);
    assign grant      = {req1_ready, req0_ready};
    assign accept     = |grant;

    assign mux_a    = winner ? req1_a    : req0_a;
    assign mux_b    = winner ? req1_b    : req0_b;
    assign mux_ctrl = winner ? req1_ctrl : req0_ctrl;

    ALU u_alu (
        .ctrl   (mux_ctrl),
        .a      (mux_a),
        .b      (mux_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg        <= 1'b1;
            rsp_valid_reg   <= 1'b0;
            rsp_result_reg  <= 32'd0;
            rsp_zero_reg    <= 1'b0;
            rsp_neg_reg     <= 1'b0;
            rsp_id_reg      <= 1'b0;
            rsp_illegal_reg <= 1'b0;
        end else if (accept) begin
            last_reg        <= winner;
            rsp_valid_reg   <= 1'b1;
            rsp_result_reg  <= alu_result;
            rsp_zero_reg    <= alu_zero;
            rsp_neg_reg     <= alu_result[31];
            rsp_id_reg      <= winner;
            rsp_illegal_reg <= !alu_ctrl_legal(mux_ctrl);
        end else if (rsp_ready) begin
            rsp_valid_reg   <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst)
                cnt_reg[gi] <= '0;
            else if (grant[gi])
                cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_result  = rsp_result_reg;
    assign rsp_zero    = rsp_zero_reg;
    assign rsp_neg     = rsp_neg_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_illegal = rsp_illegal_reg;
    assign grant_cnt0  = cnt_reg[0];
    assign grant_cnt1  = cnt_reg[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a 2-bit counter width exercises
// counter wrap within a short sequence.
module tb_alu_share_arbiter;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic             rsp_valid, rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_zero, rsp_neg, rsp_id, rsp_illegal;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ctrl   (req0_ctrl),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ctrl   (req1_ctrl),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_neg     (rsp_neg),
        .rsp_id      (rsp_id),
        .rsp_illegal (rsp_illegal),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, landing 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] res, input logic z,
                             input logic n, input logic id, input logic ill);
        check({tag, ".valid"},   {31'd0, rsp_valid},   32'd1);
        check({tag, ".result"},  rsp_result,           res);
        check({tag, ".zero"},    {31'd0, rsp_zero},    {31'd0, z});
        check({tag, ".neg"},     {31'd0, rsp_neg},     {31'd0, n});
        check({tag, ".id"},      {31'd0, rsp_id},      {31'd0, id});
        check({tag, ".illegal"}, {31'd0, rsp_illegal}, {31'd0, ill});
        $display("txn %s: result=%h zero=%0b neg=%0b id=%0b illegal=%0b",
                 tag, rsp_result, rsp_zero, rsp_neg, rsp_id, rsp_illegal);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        set0(1'b1, 32'd5, 32'd7, 4'b0010);
        set1(1'b0, 32'd0, 32'd0, 4'b0000);

        // Reset: readys low even with a valid request.
        tick();
        tick();
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);

        rst = 1'b0;
        rsp_ready = 1'b1;
        settle();
        check("reset.valid",   {31'd0, rsp_valid},   32'd0);
        check("reset.result",  rsp_result,           32'd0);
        check("reset.zero",    {31'd0, rsp_zero},    32'd0);
        check("reset.neg",     {31'd0, rsp_neg},     32'd0);
        check("reset.id",      {31'd0, rsp_id},      32'd0);
        check("reset.illegal", {31'd0, rsp_illegal}, 32'd0);
        check("reset.cnt0",    {30'd0, grant_cnt0},  32'd0);
        check("reset.cnt1",    {30'd0, grant_cnt1},  32'd0);
        check("first_ready0",  {31'd0, req0_ready},  32'd1);

        // ADD 5+7 from requester 0.
        tick();
        check_rsp("add", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        check("add.cnt0", {30'd0, grant_cnt0}, 32'd1);

        // Illegal ctrl from requester 1.
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        set1(1'b1, 32'd9, 32'd0, 4'b1010);
        settle();
        check("ill.ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        check_rsp("illegal", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("ill.cnt1", {30'd0, grant_cnt1}, 32'd1);

        // Both valid, 4 cycles: alternating 0,1,0,1.
        set0(1'b1, 32'd3, 32'd3, 4'b0110);
        set1(1'b1, 32'd0, 32'd0, 4'b1100);
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr.ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr.ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (i % 2 == 0)
                check_rsp("rr_sub", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            else
                check_rsp("rr_nor", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        check("rr.cnt0", {30'd0, grant_cnt0}, 32'd3);
        check("rr.cnt1", {30'd0, grant_cnt1}, 32'd3);

        // Drain with no requests: valid clears, data holds.
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        tick();
        check("drain.valid",  {31'd0, rsp_valid}, 32'd0);
        check("drain.result", rsp_result,         32'hFFFF_FFFF);
        check("drain.id",     {31'd0, rsp_id},    32'd1);

        // Backpressure: exactly one accept while rsp_ready is low.
        rsp_ready = 1'b0;
        set0(1'b1, 32'd3, 32'd3, 4'b0110);
        set1(1'b1, 32'd0, 32'd0, 4'b1100);
        settle();
        check("bp.ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        check_rsp("bp_first", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("bp.cnt0_wrap", {30'd0, grant_cnt0}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check("bp.hold_ready0", {31'd0, req0_ready}, 32'd0);
            check("bp.hold_ready1", {31'd0, req1_ready}, 32'd0);
            tick();
            check_rsp("bp_hold", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Release: held response drains and requester 1 is accepted together.
        rsp_ready = 1'b1;
        settle();
        check("rel.ready1", {31'd0, req1_ready}, 32'd1);
        check("rel.ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        check_rsp("release", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rel.cnt1_wrap", {30'd0, grant_cnt1}, 32'd0);

        // Reset while a response is pending.
        rsp_ready = 1'b0;
        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        check("rst2.valid",  {31'd0, rsp_valid},  32'd0);
        check("rst2.cnt0",   {30'd0, grant_cnt0}, 32'd0);
        check("rst2.cnt1",   {30'd0, grant_cnt1}, 32'd0);
        check("rst2.result", rsp_result,          32'd0);

        // Tie after reset goes to requester 0; SLT 2<9 yields 1.
        set0(1'b1, 32'd2, 32'd9, 4'b0111);
        set1(1'b1, 32'd0, 32'd0, 4'b1100);
        settle();
        check("rst2.tie_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        check_rsp("slt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("slt.cnt0", {30'd0, grant_cnt0}, 32'd1);

        // Three more requester-0 ops take the 2-bit counter around to 0.
        set1(1'b0, 32'd0, 32'd0, 4'b0000);
        set0(1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0001);
        tick();
        check_rsp("or", 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("or.cnt0", {30'd0, grant_cnt0}, 32'd2);
        set0(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0010);
        tick();
        check_rsp("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("add_ovf.cnt0", {30'd0, grant_cnt0}, 32'd3);
        set0(1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0000);
        tick();
        check_rsp("and", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("and.cnt0_wrap", {30'd0, grant_cnt0}, 32'd0);
        check("and.cnt1",      {30'd0, grant_cnt1}, 32'd0);

        set0(1'b0, 32'd0, 32'd0, 4'b0000);
        tick();
        check("end.valid", {31'd0, rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one instance of the combinational `ALU` between two independent requesters: requester 0 is the execute-stage issue path and requester 1 is the branch/compare unit. The block arbitrates round-robin over valid/ready request channels and drives the winner's operands into the `ALU`. It registers the result, flags and requester tag into a one-entry response buffer, presented on a valid/ready response channel. Throughput is one operation per cycle; latency is one cycle.

## Interface
- `CNT_W`, default 16: width of the per-requester grant counters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b` in 32 each: operands A and B.
- `req0_ctrl` in 4: ALU control code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_ctrl`: same as requester 0, for requester 1.
- `rsp_valid` out 1: the response buffer holds a result.
- `rsp_ready` in 1: the consumer takes the response this cycle.
- `rsp_result` out 32: ALU result.
- `rsp_zero`, `rsp_neg` out 1 each: zero and negative flags of `rsp_result`.
- `rsp_id` out 1: index of the requester that issued the operation.
- `rsp_illegal` out 1: ctrl was not one of AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `grant_cnt0`, `grant_cnt1` out `CNT_W` each: accepted-operation counts; wrap modulo 2^CNT_W.

## Operation
- `can_accept = !rst && (!rsp_valid || rsp_ready)`.
- Grant selection depends only on the valid inputs and `last`, never on any ready signal.
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the requester other than `last` wins.
- `reqN_ready = can_accept && reqN_valid && (winner == N)`. At most one ready is high per cycle.
- Accept occurs when `reqN_valid && reqN_ready`. On the same edge:
  - the winner's a/b/ctrl drive the ALU;
  - the ALU result, zero, neg, `N` and the illegal flag load into the rsp registers, and `rsp_valid` is set;
  - `last` is set to N and `grant_cntN` increments.
- No accept, but `rsp_valid && rsp_ready`: `rsp_valid` clears and the rsp data registers hold their values.
- Accept and drain in the same cycle: the buffer reloads and `rsp_valid` stays 1.
- Requester rule: once `reqN_valid` rises, a/b/ctrl and valid hold until ready. The arbiter does not check this.
- Illegal ctrl: the ALU returns 0, so the block outputs result=0, zero=1, neg=0, illegal=1. The requester is still granted and counted.
- SLT is an unsigned compare and yields 1 or 0; the width is always 32 bits.
- Counters wrap from 2^CNT_W-1 to 0 with no saturation.

## Timing
- Reset values: `rsp_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_neg`=0, `rsp_id`=0, `rsp_illegal`=0, `last`=1 (requester 0 wins the first tie), `grant_cnt0`=`grant_cnt1`=0. Both readys are 0 while `rst`=1.
- Reset mid-operation discards any pending response. Requesters whose valid was not accepted re-present after reset.
- Latency: accept at edge k makes the response visible after edge k, for the whole of cycle k+1.
- Backpressure: while `rsp_valid && !rsp_ready`, both readys are 0 and all rsp outputs are stable.
- Sustained `rsp_ready`=1 with both requesters valid gives one accept per cycle, alternating 0,1,0,1.

## Structure
- Shared package `alu_pkg`:
  - ALU ctrl localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`;
  - function `alu_ctrl_legal`.
- One sub-module: the existing `ALU`, instantiated once, fed by the grant mux.
- The arbiter, response buffer and counters live in this module.

## Test plan
- Reset, then idle: all outputs at reset values; `req0_valid`=1 gives `req0_ready`=1 in the first post-reset cycle.
- req0 ADD 5+7, `rsp_ready`=1: next cycle result=12, zero=0, neg=0, id=0, illegal=0; `grant_cnt0`=1.
- Both valid for 4 cycles, `rsp_ready`=1: ids 0,1,0,1. Ops are req0 SUB 3-3 (zero=1) and req1 NOR 0,0 (result=0xFFFFFFFF, neg=1).
- Hold `rsp_ready`=0 for 3 cycles with both valid: exactly one accept, then both readys=0 and the rsp stays stable. Release: the held response drains and the next accept happens in the same cycle.
- req1 ctrl 4'b1010 with a=9: result=0, zero=1, illegal=1, id=1; `grant_cnt1` increments.
- Assert `rst` for 1 cycle while `rsp_valid`=1: `rsp_valid`=0 and counters=0 after the edge; the next tie goes to requester 0. SLT 2,9 afterwards gives result=1. Preload `CNT_W`=2 and run 4 req0 ops: `grant_cnt0` wraps to 0.
